// File: rtl/dcm_lock_sequencer.sv
// Brings the DCM out of reset, waits for a stable LOCKED, then releases the system.
// Retries failed lock attempts up to MAX_RETRIES and restarts the sequence on lock loss.
module dcm_lock_sequencer #(
  parameter int DCM_RST_CYCLES = 8,
  parameter int LOCK_TIMEOUT   = 100000,
  parameter int STABLE_CYCLES  = 1024,
  parameter int MAX_RETRIES    = 4
) (
  input  logic       clk100,
  input  logic       rst_n,
  input  logic       dcm_locked,
  output logic       dcm_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic       fault,
  output logic       lock_lost,
  output logic [2:0] retry_count
);

  localparam int SYNC_STAGES = 2;
  localparam int CNT_MAX_A   = (LOCK_TIMEOUT > STABLE_CYCLES) ? LOCK_TIMEOUT : STABLE_CYCLES;
  localparam int CNT_MAX     = (CNT_MAX_A > DCM_RST_CYCLES) ? CNT_MAX_A : DCM_RST_CYCLES;
  localparam int CNT_W       = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [2:0] {
    RESET_DCM,
    WAIT_LOCK,
    STABLE,
    RUN,
    FAULT
  } state_t;

  state_t                 state_reg, state_next;
  logic [CNT_W-1:0]       cnt_reg, cnt_next;
  logic [2:0]             retry_reg, retry_next;
  logic [2:0]             retry_inc;
  logic                   lock_lost_reg, lock_lost_next;
  logic                   dcm_rst_reg, sys_rst_reg, ready_reg, fault_reg;
  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   locked_s;

  // dcm_locked comes from the DCM asynchronously to clk100
  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], dcm_locked};
    end
  end

  assign locked_s  = sync_reg[SYNC_STAGES-1];
  assign retry_inc = retry_reg + 3'd1;

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    retry_next     = retry_reg;
    lock_lost_next = lock_lost_reg;
    case (state_reg)
      RESET_DCM: begin
        if (cnt_reg == CNT_W'(DCM_RST_CYCLES - 1)) begin
          state_next = WAIT_LOCK;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      WAIT_LOCK: begin
        // a lock seen on the final timeout cycle still counts as a lock
        if (locked_s) begin
          state_next = STABLE;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_W'(LOCK_TIMEOUT - 1)) begin
          retry_next = retry_inc;
          cnt_next   = '0;
          state_next = (retry_inc == 3'(MAX_RETRIES)) ? FAULT : RESET_DCM;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      STABLE: begin
        // short dropouts go back to waiting without resetting the DCM
        if (!locked_s) begin
          state_next = WAIT_LOCK;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_W'(STABLE_CYCLES - 1)) begin
          state_next = RUN;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      RUN: begin
        retry_next = '0;
        if (!locked_s) begin
          state_next     = RESET_DCM;
          lock_lost_next = 1'b1;
          cnt_next       = '0;
        end
      end
      FAULT: begin
        cnt_next   = '0;
        retry_next = 3'(MAX_RETRIES);
      end
      default: begin
        state_next = RESET_DCM;
        cnt_next   = '0;
      end
    endcase
    if (state_next == RUN) begin
      retry_next = '0;
    end
  end

  // outputs are registered from the next state so they change on the same edge
  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= RESET_DCM;
      cnt_reg       <= '0;
      retry_reg     <= '0;
      lock_lost_reg <= 1'b0;
      dcm_rst_reg   <= 1'b1;
      sys_rst_reg   <= 1'b1;
      ready_reg     <= 1'b0;
      fault_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      retry_reg     <= retry_next;
      lock_lost_reg <= lock_lost_next;
      dcm_rst_reg   <= (state_next == RESET_DCM) || (state_next == FAULT);
      sys_rst_reg   <= (state_next != RUN);
      ready_reg     <= (state_next == RUN);
      fault_reg     <= (state_next == FAULT);
    end
  end

  assign dcm_rst     = dcm_rst_reg;
  assign sys_rst     = sys_rst_reg;
  assign ready       = ready_reg;
  assign fault       = fault_reg;
  assign lock_lost   = lock_lost_reg;
  assign retry_count = retry_reg;

endmodule

// File: tb/tb_dcm_lock_sequencer.sv
// Directed scenarios plus randomized LOCKED activity, each cycle compared against a
// phase/elapsed-time reference model of the bring-up rules.
module tb_dcm_lock_sequencer;

  localparam int N = 4;
  localparam int T = 64;
  localparam int S = 16;
  localparam int R = 3;

  localparam int P_RST   = 0;
  localparam int P_WAIT  = 1;
  localparam int P_STAB  = 2;
  localparam int P_RUN   = 3;
  localparam int P_FAULT = 4;

  logic       clk100 = 1'b0;
  logic       rst_n = 1'b0;
  logic       dcm_locked = 1'b0;
  logic       dcm_rst, sys_rst, ready, fault, lock_lost;
  logic [2:0] retry_count;
  logic [7:0] dut_vec;

  int checks = 0;
  int errors = 0;
  int edge_no = 0;

  int m_phase, m_elapsed, m_retries;
  bit m_lost;
  bit sync_q[$];

  always #5 clk100 = ~clk100;

  dcm_lock_sequencer #(
    .DCM_RST_CYCLES(N),
    .LOCK_TIMEOUT  (T),
    .STABLE_CYCLES (S),
    .MAX_RETRIES   (R)
  ) dut (
    .clk100     (clk100),
    .rst_n      (rst_n),
    .dcm_locked (dcm_locked),
    .dcm_rst    (dcm_rst),
    .sys_rst    (sys_rst),
    .ready      (ready),
    .fault      (fault),
    .lock_lost  (lock_lost),
    .retry_count(retry_count)
  );

  assign dut_vec = {dcm_rst, sys_rst, ready, fault, lock_lost, retry_count};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model_vec();
    logic [7:0] v;
    v[7]   = (m_phase == P_RST) || (m_phase == P_FAULT);
    v[6]   = (m_phase != P_RUN);
    v[5]   = (m_phase == P_RUN);
    v[4]   = (m_phase == P_FAULT);
    v[3]   = m_lost;
    v[2:0] = 3'(m_retries);
    return v;
  endfunction

  task automatic model_reset();
    m_phase   = P_RST;
    m_elapsed = 0;
    m_retries = 0;
    m_lost    = 1'b0;
    sync_q    = {1'b0, 1'b0};
  endtask

  task automatic enter(input int p);
    m_phase   = p;
    m_elapsed = 0;
    if (p == P_RUN) m_retries = 0;
  endtask

  // lk is what the DUT samples at this edge; the FSM acts on the value from two edges back
  task automatic model_step(input bit lk);
    bit ls;
    ls = sync_q.pop_front();
    sync_q.push_back(lk);
    case (m_phase)
      P_RST: begin
        m_elapsed++;
        if (m_elapsed == N) enter(P_WAIT);
      end
      P_WAIT: begin
        if (ls) enter(P_STAB);
        else begin
          m_elapsed++;
          if (m_elapsed == T) begin
            m_retries++;
            enter((m_retries == R) ? P_FAULT : P_RST);
          end
        end
      end
      P_STAB: begin
        if (!ls) enter(P_WAIT);
        else begin
          m_elapsed++;
          if (m_elapsed == S) enter(P_RUN);
        end
      end
      P_RUN: begin
        if (!ls) begin
          m_lost = 1'b1;
          enter(P_RST);
        end
      end
      default: ;
    endcase
  endtask

  task automatic tick(input bit lk);
    dcm_locked = lk;
    @(posedge clk100);
    model_step(lk);
    edge_no++;
    @(negedge clk100);
    check($sformatf("cycle_e%0d", edge_no), dut_vec, model_vec());
  endtask

  // asserts rst_n between edges and checks outputs before any edge occurs
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("async_rst_model", dut_vec, model_vec());
    check("async_rst_vals", dut_vec, 8'hC0);
    @(negedge clk100);
    rst_n   = 1'b1;
    edge_no = 0;
  endtask

  task automatic wait_ready(input int budget, output int rst_hi);
    rst_hi = 0;
    for (int i = 0; i < budget && !ready; i++) begin
      tick(1'b1);
      rst_hi += int'(dcm_rst);
    end
  endtask

  initial begin
    int t0, rst_hi, e1, e2, ef;
    bit lk;
    int len;

    model_reset();
    @(negedge clk100);

    // 1: normal bring-up
    do_reset();
    repeat (3) tick(1'b0);
    check("s1_dcm_rst_hi", dcm_rst, 1);
    tick(1'b0);
    check("s1_dcm_rst_lo", dcm_rst, 0);
    repeat (10) tick(1'b0);
    t0 = edge_no;
    wait_ready(40, rst_hi);
    check("s1_ready_edge", edge_no, t0 + 19);
    check("s1_sys_rst", sys_rst, 0);
    check("s1_retry", retry_count, 0);

    // 2: never locks
    do_reset();
    e1 = -1; e2 = -1; ef = -1;
    for (int i = 0; i < 260 && !fault; i++) begin
      tick(1'b0);
      if (retry_count == 3'd1 && e1 < 0) e1 = edge_no;
      if (retry_count == 3'd2 && e2 < 0) e2 = edge_no;
    end
    if (fault) ef = edge_no;
    check("s2_retry1_edge", e1, 68);
    check("s2_retry2_edge", e2, 136);
    check("s2_fault_edge", ef, 204);
    check("s2_retry3", retry_count, 3);
    repeat (30) tick(1'b0);
    check("s2_dcm_rst_held", dcm_rst, 1);
    check("s2_fault_held", fault, 1);

    // 3: glitch during STABLE
    do_reset();
    repeat (4) tick(1'b0);
    repeat (11) tick(1'b1);
    rst_hi = 0;
    for (int i = 0; i < 5; i++) begin
      tick(1'b0);
      rst_hi += int'(dcm_rst);
    end
    check("s3_no_pulse_glitch", rst_hi, 0);
    t0 = edge_no;
    wait_ready(40, rst_hi);
    check("s3_no_pulse_relock", rst_hi, 0);
    check("s3_ready_edge", edge_no, t0 + 19);
    check("s3_retry", retry_count, 0);

    // 4: lock loss in RUN
    tick(1'b0);
    tick(1'b0);
    check("s4_ready_edge2", ready, 1);
    tick(1'b0);
    check("s4_ready_edge3", ready, 0);
    check("s4_lock_lost", lock_lost, 1);
    check("s4_dcm_rst", dcm_rst, 1);
    check("s4_sys_rst", sys_rst, 1);
    repeat (3) tick(1'b0);
    check("s4_pulse_hi", dcm_rst, 1);
    tick(1'b0);
    check("s4_pulse_lo", dcm_rst, 0);
    wait_ready(40, rst_hi);
    check("s4_relock_ready", ready, 1);
    check("s4_lost_sticky", lock_lost, 1);

    // 5: lock on the last WAIT_LOCK cycle of attempt 2
    do_reset();
    repeat (133) tick(1'b0);
    check("s5_retry_before", retry_count, 1);
    repeat (3) tick(1'b1);
    check("s5_lock_wins_retry", retry_count, 1);
    check("s5_lock_wins_dcm", dcm_rst, 0);
    wait_ready(40, rst_hi);
    check("s5_ready", ready, 1);
    check("s5_retry_clr", retry_count, 0);

    // 6: async reset mid-STABLE and in FAULT
    do_reset();
    repeat (4) tick(1'b0);
    repeat (8) tick(1'b1);
    do_reset();
    repeat (4) tick(1'b0);
    t0 = edge_no;
    wait_ready(40, rst_hi);
    check("s6_restart_ready_edge", edge_no, t0 + 19);
    do_reset();
    repeat (204) tick(1'b0);
    check("s6_fault", fault, 1);
    do_reset();
    check("s6_fault_cleared", fault, 0);
    repeat (3) tick(1'b0);
    check("s6_restart_dcm_rst", dcm_rst, 1);
    check("s6_restart_no_fault", fault, 0);

    // randomized LOCKED activity with occasional resets
    do_reset();
    for (int seg = 0; seg < 60; seg++) begin
      if ($urandom_range(0, 14) == 0) do_reset();
      lk  = 1'($urandom_range(0, 1));
      len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(100, 250))
                                        : int'($urandom_range(1, 30));
      repeat (len) tick(lk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
